uivtc_line_rd_sched: RTL and testbench

- Per-line DDR read scheduler for the two-window display path: window 0 carries the original video and window 1 carries the 180-degree-rotated video.
- Tracks the VTC line sequence and, one line ahead of display, requests one line burst per visible window.
- Arbitrates both windows round-robin onto a single DDR read-command port.
- Window 1 line addresses run bottom-up, and each window-1 burst is flagged for reversed line-buffer write, which produces the 180-degree rotation.

---
 rtl/uivtc_line_rd_sched.sv | 169 ++++++++++++++++
 tb/tb_uivtc_line_rd_sched.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uivtc_line_rd_sched.sv
// uivtc_line_rd_sched: per-line DDR read scheduler for the two-window display
// path (window 0 = original video, window 1 = 180-degree rotated video).
// One line ahead of display, each visible line requests one burst per window.
// Both windows share one read-command port under round-robin arbitration.
// Optional statistics outputs are enabled by defining UIVTC_LINE_SCHED_STAT_EN.
module uivtc_line_rd_sched #(
    parameter int unsigned        ADDR_W        = 32,
    parameter int unsigned        H2_ActiveSize = 640,
    parameter int unsigned        V2_ActiveSize = 360,
    parameter int unsigned        VTC_Y         = 180,
    parameter int unsigned        BYTES_PER_PIX = 4,
    parameter logic [ADDR_W-1:0]  BASE0         = 32'h0000_0000,
    parameter logic [ADDR_W-1:0]  BASE1         = 32'h0100_0000
) (
    input  logic              I_vtc_clk,
    input  logic              I_vtc_rst,
    input  logic              I_frame_start,
    input  logic              I_line_start,
    output logic              O_rd_req,
    output logic [ADDR_W-1:0] O_rd_addr,
    output logic [15:0]       O_rd_len,
    output logic              O_rd_win,
    output logic              O_rd_reverse,
    input  logic              I_rd_ack,
    input  logic              I_rd_done,
    output logic              O_busy,
`ifdef UIVTC_LINE_SCHED_STAT_EN
    output logic [7:0]        O_overrun_cnt,
    output logic [11:0]       O_line_cnt,
`endif
    output logic              O_overrun
);

    localparam int unsigned       STRIDE   = H2_ActiveSize * BYTES_PER_PIX;
    localparam logic [15:0]       LEN      = 16'(STRIDE);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
    localparam logic [12:0]       Y_LO     = 13'(VTC_Y);
    localparam logic [12:0]       Y_HI     = 13'(VTC_Y + V2_ActiveSize);
    localparam logic [11:0]       LAST_ROW = 12'(V2_ActiveSize - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [11:0]       nxt_line;
    logic [11:0]       line_upd;
    logic [11:0]       li;
    logic [11:0]       li_new;
    logic [11:0]       row;
    logic [1:0]        pending;
    logic [1:0]        pend_nxt;
    logic [1:0]        clr;
    logic              trig;
    logic              in_win;
    logic              ovr_now;
    logic              last_grant;
    logic              gnt_win;
    logic [ADDR_W-1:0] gnt_addr;

    // Line tracking, trigger decode and pending-bit next state
    always_comb begin
        line_upd = nxt_line;
        if (I_frame_start)
            line_upd = '0;
        else if (I_line_start && nxt_line != 12'hFFF)
            line_upd = nxt_line + 12'd1;
        trig   = I_frame_start | I_line_start;
        in_win = trig && ({1'b0, line_upd} >= Y_LO) && ({1'b0, line_upd} < Y_HI);
        li_new = 12'({1'b0, line_upd} - Y_LO);
        clr = '0;
        if (state == REQ && I_rd_ack)
            clr[O_rd_win] = 1'b1;
        // A frame start clears pending first, so it can never report an overrun;
        // a bit being acked this cycle is not counted as still pending.
        ovr_now  = in_win && !I_frame_start && |(pending & ~clr);
        pend_nxt = pending & ~clr;
        if (I_frame_start)
            pend_nxt = '0;
        if (in_win)
            pend_nxt = 2'b11;
    end

    // Round-robin grant and line address for the window that would be granted
    always_comb begin
        gnt_win  = (pending == 2'b11) ? ~last_grant : ~pending[0];
        row      = gnt_win ? (LAST_ROW - li) : li;
        gnt_addr = (gnt_win ? BASE1 : BASE0) + ADDR_W'(row) * STRIDE_A;
    end

    // Line counter, pending bits, latched line index and sticky overrun flag
    always_ff @(posedge I_vtc_clk) begin
        if (I_vtc_rst) begin
            nxt_line  <= '0;
            pending   <= '0;
            li        <= '0;
            O_overrun <= 1'b0;
        end else begin
            if (trig)
                nxt_line <= line_upd;
            pending <= pend_nxt;
            if (in_win)
                li <= li_new;
            if (ovr_now)
                O_overrun <= 1'b1;
        end
    end

    // Request FSM: grant, hold command until ack, then wait for burst completion
    always_ff @(posedge I_vtc_clk) begin
        if (I_vtc_rst) begin
            state        <= IDLE;
            O_rd_req     <= 1'b0;
            O_rd_addr    <= '0;
            O_rd_len     <= '0;
            O_rd_win     <= 1'b0;
            O_rd_reverse <= 1'b0;
            last_grant   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        O_rd_req     <= 1'b1;
                        O_rd_addr    <= gnt_addr;
                        O_rd_len     <= LEN;
                        O_rd_win     <= gnt_win;
                        O_rd_reverse <= gnt_win;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    if (I_rd_ack) begin
                        O_rd_req   <= 1'b0;
                        last_grant <= O_rd_win;
                        state      <= I_rd_done ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (I_rd_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign O_busy = (state != IDLE);

`ifdef UIVTC_LINE_SCHED_STAT_EN
    // Per-frame statistics: overrun events and accepted line requests
    always_ff @(posedge I_vtc_clk) begin
        if (I_vtc_rst) begin
            O_overrun_cnt <= '0;
            O_line_cnt    <= '0;
        end else if (I_frame_start) begin
            O_overrun_cnt <= '0;
            O_line_cnt    <= '0;
        end else begin
            if (ovr_now && O_overrun_cnt != 8'hFF)
                O_overrun_cnt <= O_overrun_cnt + 8'd1;
            if (|clr && O_line_cnt != 12'hFFF)
                O_line_cnt <= O_line_cnt + 12'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uivtc_line_rd_sched.sv
// Scoreboard testbench for uivtc_line_rd_sched with a transaction-level model.
module tb_uivtc_line_rd_sched;

    localparam int          H   = 640;
    localparam int          V   = 360;
    localparam int          VY  = 180;
    localparam int          BPP = 4;
    localparam int          STR = H * BPP;
    localparam logic [31:0] B0  = 32'h0000_0000;
    localparam logic [31:0] B1  = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        I_vtc_rst;
    logic        I_frame_start;
    logic        I_line_start;
    logic        O_rd_req;
    logic [31:0] O_rd_addr;
    logic [15:0] O_rd_len;
    logic        O_rd_win;
    logic        O_rd_reverse;
    logic        I_rd_ack;
    logic        I_rd_done;
    logic        O_busy;
    logic        O_overrun;
`ifdef UIVTC_LINE_SCHED_STAT_EN
    logic [7:0]  O_overrun_cnt;
    logic [11:0] O_line_cnt;
`endif

    uivtc_line_rd_sched #(
        .ADDR_W(32), .H2_ActiveSize(H), .V2_ActiveSize(V), .VTC_Y(VY),
        .BYTES_PER_PIX(BPP), .BASE0(B0), .BASE1(B1)
    ) dut (
        .I_vtc_clk(clk), .I_vtc_rst(I_vtc_rst),
        .I_frame_start(I_frame_start), .I_line_start(I_line_start),
        .O_rd_req(O_rd_req), .O_rd_addr(O_rd_addr), .O_rd_len(O_rd_len),
        .O_rd_win(O_rd_win), .O_rd_reverse(O_rd_reverse),
        .I_rd_ack(I_rd_ack), .I_rd_done(I_rd_done), .O_busy(O_busy),
`ifdef UIVTC_LINE_SCHED_STAT_EN
        .O_overrun_cnt(O_overrun_cnt), .O_line_cnt(O_line_cnt),
`endif
        .O_overrun(O_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] a;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   ack_cnt = 0;
    int   m_line = 0;
    int   ack_max = 0;
    int   done_max = 0;
    bit   hold_ack = 0;
    bit   hold_done = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] line_addr(input logic w, input int li);
        logic [31:0] row;
        row = w ? 32'(V - 1 - li) : 32'(li);
        return (w ? B1 : B0) + row * 32'(STR);
    endfunction

    function automatic void push_exp(input logic w, input int li);
        exp_t e;
        e.w = w;
        e.a = line_addr(w, li);
        expq.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one VTC pulse and advance the line model; returns whether it was visible
    task automatic pulse(input logic fs, input logic ls, input bit push, output bit vis);
        int L;
        I_frame_start = fs;
        I_line_start  = ls;
        if (fs)                L = 0;
        else if (m_line >= 4095) L = 4095;
        else                   L = m_line + 1;
        m_line = L;
        vis = (L >= VY) && (L < VY + V);
        if (push && vis) begin
            push_exp(1'b0, L - VY);
            push_exp(1'b1, L - VY);
        end
        tick();
        I_frame_start = 1'b0;
        I_line_start  = 1'b0;
    endtask

    task automatic run_lines(input int n, input int lo, input int hi);
        bit vis;
        for (int i = 0; i < n; i++) begin
            pulse(1'b0, 1'b1, 1'b1, vis);
            if (vis) repeat ($urandom_range(hi, lo)) tick();
            else tick();
        end
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 3000) begin
            tick();
            n++;
            quiet = O_busy ? 0 : quiet + 1;
        end
        chk("idle_reached", 32'(quiet >= 4), 32'd1);
    endtask

    // Read-port responder: random ack and done latencies, optionally held off
    initial begin
        int d;
        int dd;
        int k;
        I_rd_ack  = 1'b0;
        I_rd_done = 1'b0;
        forever begin
            tick();
            if (O_rd_req && !hold_ack && !I_vtc_rst) begin
                d = $urandom_range(ack_max, 0);
                repeat (d) tick();
                dd = $urandom_range(done_max, 0);
                I_rd_ack  = 1'b1;
                I_rd_done = (dd == 0 && !hold_done);
                tick();
                I_rd_ack = 1'b0;
                if (I_rd_done) begin
                    I_rd_done = 1'b0;
                end else begin
                    if (dd > 1) repeat (dd - 1) tick();
                    k = 0;
                    while (hold_done && k < 5000) begin
                        tick();
                        k++;
                    end
                    I_rd_done = 1'b1;
                    tick();
                    I_rd_done = 1'b0;
                end
            end
        end
    end

    // Monitor: command stability while unacked, scoreboard pop on each handshake
    logic        p_req = 1'b0;
    logic [31:0] p_addr;
    logic        p_win;
    logic        p_rev;
    always @(negedge clk) begin
        exp_t e;
        if (I_vtc_rst) begin
            p_req = 1'b0;
        end else begin
            if (p_req && O_rd_req) begin
                chk("hold_addr", O_rd_addr, p_addr);
                chk("hold_win", 32'(O_rd_win), 32'(p_win));
                chk("hold_rev", 32'(O_rd_reverse), 32'(p_rev));
            end
            if (O_rd_req && I_rd_ack) begin
                ack_cnt++;
                chk("sb_nonempty", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("req_win", 32'(O_rd_win), 32'(e.w));
                    chk("req_addr", O_rd_addr, e.a);
                    chk("req_rev", 32'(O_rd_reverse), 32'(e.w));
                    chk("req_len", 32'(O_rd_len), 32'(STR));
                end
                p_req = 1'b0;
            end else begin
                p_req  = O_rd_req;
                p_addr = O_rd_addr;
                p_win  = O_rd_win;
                p_rev  = O_rd_reverse;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a0;
        int n;
        bit vis;
        I_vtc_rst     = 1'b1;
        I_frame_start = 1'b0;
        I_line_start  = 1'b0;
        repeat (3) tick();
        I_vtc_rst = 1'b0;
        chk("rst_req", 32'(O_rd_req), 32'd0);
        chk("rst_addr", O_rd_addr, 32'd0);
        chk("rst_len", 32'(O_rd_len), 32'd0);
        chk("rst_win", 32'(O_rd_win), 32'd0);
        chk("rst_rev", 32'(O_rd_reverse), 32'd0);
        chk("rst_busy", 32'(O_busy), 32'd0);
        chk("rst_overrun", 32'(O_overrun), 32'd0);

        // Full frame, instant ack/done
        a0 = ack_cnt;
        pulse(1'b1, 1'b0, 1'b1, vis);
        run_lines(179, 8, 8);
        tick(); tick(); tick();
        chk("no_req_before_180", 32'(ack_cnt - a0), 32'd0);
        run_lines(1125 - 179, 8, 8);
        wait_idle();
        chk("frame_acks_instant", 32'(ack_cnt - a0), 32'd720);
        chk("frame_overrun_instant", 32'(O_overrun), 32'd0);
        chk("frame_sb_empty", 32'(expq.size()), 32'd0);
`ifdef UIVTC_LINE_SCHED_STAT_EN
        chk("stat_line_cnt", 32'(O_line_cnt), 32'd720);
`endif

        // Full frame, random handshake latencies and line spacing
        ack_max = 3; done_max = 3;
        a0 = ack_cnt;
        pulse(1'b1, 1'b0, 1'b1, vis);
        run_lines(1125, 24, 32);
        wait_idle();
        chk("frame_acks_random", 32'(ack_cnt - a0), 32'd720);
        chk("frame_overrun_random", 32'(O_overrun), 32'd0);

        // Line counter saturates at 4095 rather than wrapping into the window again
        ack_max = 0; done_max = 0;
        a0 = ack_cnt;
        pulse(1'b1, 1'b0, 1'b1, vis);
        run_lines(4300, 8, 8);
        wait_idle();
        chk("sat_acks", 32'(ack_cnt - a0), 32'd720);
        chk("sat_sb_empty", 32'(expq.size()), 32'd0);

        // Ack held across two visible lines: overrun, one request per window
        a0 = ack_cnt;
        pulse(1'b1, 1'b0, 1'b1, vis);
        run_lines(179, 8, 8);
        hold_ack = 1;
        pulse(1'b0, 1'b1, 1'b0, vis);
        repeat (4) tick();
        chk("ovr_req_up", 32'(O_rd_req), 32'd1);
        chk("ovr_first_addr", O_rd_addr, B0);
        chk("ovr_flag_before", 32'(O_overrun), 32'd0);
        pulse(1'b0, 1'b1, 1'b0, vis);
        repeat (4) tick();
        chk("ovr_flag", 32'(O_overrun), 32'd1);
        chk("ovr_req_held", 32'(O_rd_req), 32'd1);
        push_exp(1'b0, 0);
        push_exp(1'b1, 1);
        hold_ack = 0;
        wait_idle();
        chk("ovr_acks", 32'(ack_cnt - a0), 32'd2);
        chk("ovr_sticky", 32'(O_overrun), 32'd1);

        // Coincident frame/line start restarts the count at 0
        a0 = ack_cnt;
        pulse(1'b1, 1'b1, 1'b1, vis);
        run_lines(179, 8, 8);
        repeat (4) tick();
        chk("coinc_no_req", 32'(ack_cnt - a0), 32'd0);
        run_lines(1, 8, 8);
        wait_idle();
        chk("coinc_acks", 32'(ack_cnt - a0), 32'd2);

        // Frame start while a burst is in WAIT: burst completes, window 1 dropped
        a0 = ack_cnt;
        hold_done = 1;
        pulse(1'b1, 1'b0, 1'b1, vis);
        run_lines(179, 8, 8);
        pulse(1'b0, 1'b1, 1'b0, vis);
        push_exp(1'b0, 0);
        n = 0;
        while (ack_cnt == a0 && n < 50) begin
            tick();
            n++;
        end
        chk("wait_ack_seen", 32'(ack_cnt - a0), 32'd1);
        tick();
        chk("wait_busy", 32'(O_busy), 32'd1);
        pulse(1'b1, 1'b0, 1'b1, vis);
        repeat (3) tick();
        chk("wait_busy_after_fs", 32'(O_busy), 32'd1);
        hold_done = 0;
        wait_idle();
        repeat (10) tick();
        chk("wait_acks", 32'(ack_cnt - a0), 32'd1);
        chk("wait_sb_empty", 32'(expq.size()), 32'd0);

        // Reset asserted while a request is outstanding
        a0 = ack_cnt;
        hold_ack = 1;
        run_lines(179, 8, 8);
        pulse(1'b0, 1'b1, 1'b0, vis);
        repeat (3) tick();
        pulse(1'b0, 1'b1, 1'b0, vis);
        repeat (3) tick();
        chk("rreq_req_up", 32'(O_rd_req), 32'd1);
`ifdef UIVTC_LINE_SCHED_STAT_EN
        chk("rreq_ovr_cnt_nz", 32'(O_overrun_cnt != 8'd0), 32'd1);
`endif
        I_vtc_rst = 1'b1;
        tick();
        I_vtc_rst = 1'b0;
        m_line = 0;
        expq.delete();
        chk("rreq_req", 32'(O_rd_req), 32'd0);
        chk("rreq_busy", 32'(O_busy), 32'd0);
        chk("rreq_overrun", 32'(O_overrun), 32'd0);
`ifdef UIVTC_LINE_SCHED_STAT_EN
        chk("rreq_ovr_cnt", 32'(O_overrun_cnt), 32'd0);
`endif
        hold_ack = 0;
        repeat (10) tick();
        chk("rreq_no_acks", 32'(ack_cnt - a0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
